// File: rtl/debug_pkg.sv
// Shared debug-unit definitions: frame tags, sender state encoding and
// the default payload capacity (32 registers x 4 bytes).
package debug_pkg;

  localparam int MAX_BYTES_DEFAULT = 128;

  localparam logic [7:0] TAG_REGS   = 8'h01;
  localparam logic [7:0] TAG_IF_ID  = 8'h02;
  localparam logic [7:0] TAG_ID_EX  = 8'h03;
  localparam logic [7:0] TAG_EX_MEM = 8'h04;
  localparam logic [7:0] TAG_MEM_WB = 8'h05;
  localparam logic [7:0] TAG_MEM    = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAG,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } tx_state_e;

endpackage

// File: rtl/debug_frame_tx.sv
// Framed byte sender: snapshots a wide debug vector on i_start and emits
// tag, length, payload (LSB byte first) and a two's-complement checksum
// through the UART tx_start/tx_done handshake. All outputs are registered.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
  parameter int DATA_W    = MAX_BYTES * 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_tag,
  input  logic [7:0]        i_len,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_tx_done,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam int         OFF_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [OFF_W-1:0]  bit_off;
  logic [7:0]        payload_byte;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    snap_d       = snap_q;
    len_d        = len_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    done_d       = 1'b0;
    bit_off      = OFF_W'({idx_q, 3'b000});
    payload_byte = snap_q[bit_off +: 8];

    case (state_q)
      ST_IDLE: begin
        // Start wins over a coincident tx_done; tx_done alone is ignored here.
        if (i_start) begin
          snap_d     = i_data;
          len_d      = (i_len > MAX_LEN) ? MAX_LEN : i_len;
          idx_d      = 8'd0;
          sum_d      = i_tag;
          tx_data_d  = i_tag;
          tx_start_d = 1'b1;
          state_d    = ST_TAG;
        end
      end
      ST_TAG: begin
        if (i_tx_done) begin
          tx_data_d  = len_q;
          sum_d      = sum_q + len_q;
          tx_start_d = 1'b1;
          state_d    = ST_LEN;
        end
      end
      ST_LEN: begin
        if (i_tx_done) begin
          tx_start_d = 1'b1;
          if (len_q == 8'd0) begin
            tx_data_d = 8'h00 - sum_q;
            state_d   = ST_CSUM;
          end else begin
            tx_data_d = snap_q[7:0];
            idx_d     = 8'd1;
            state_d   = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_tx_done) begin
          // The byte still held on tx_data is the one that just finished.
          sum_d      = sum_q + tx_data_q;
          tx_start_d = 1'b1;
          if (idx_q == len_q) begin
            tx_data_d = 8'h00 - sum_d;
            state_d   = ST_CSUM;
          end else begin
            tx_data_d = payload_byte;
            idx_d     = idx_q + 8'd1;
          end
        end
      end
      ST_CSUM: begin
        if (i_tx_done) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      len_q      <= 8'd0;
      idx_q      <= 8'd0;
      sum_q      <= 8'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Wide snapshot register, loaded only when a frame is accepted.
  always_ff @(posedge i_clk) begin
    // NOTE: the snapshot is left unreset; it is always written before any byte is read from it.
    snap_q <= snap_d;
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule
